lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu.sv | 201 ++++++++++++++++++++
 tb/tb_lsu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: uop codes,
// exception bit positions, FSM states and small uop decode helpers.
package lsu_pkg;

  localparam logic [7:0] UOP_NOP = 8'h00;
  localparam logic [7:0] UOP_LB  = 8'h20;
  localparam logic [7:0] UOP_LH  = 8'h21;
  localparam logic [7:0] UOP_LW  = 8'h22;
  localparam logic [7:0] UOP_LBU = 8'h24;
  localparam logic [7:0] UOP_LHU = 8'h25;
  localparam logic [7:0] UOP_SB  = 8'h28;
  localparam logic [7:0] UOP_SH  = 8'h29;
  localparam logic [7:0] UOP_SW  = 8'h2A;

  localparam int LOAD_MISALIGN  = 4;
  localparam int STORE_MISALIGN = 6;

  // ctrl stall vector: bit 4 holds the MEM stage
  localparam int   MEM_STALL_BIT = 4;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  function automatic logic is_load(input logic [7:0] u);
    return (u == UOP_LB) || (u == UOP_LH) || (u == UOP_LW) ||
           (u == UOP_LBU) || (u == UOP_LHU);
  endfunction

  function automatic logic is_store(input logic [7:0] u);
    return (u == UOP_SB) || (u == UOP_SH) || (u == UOP_SW);
  endfunction

  // access size; non-memory uops report word (never used for them)
  function automatic size_e uop_size(input logic [7:0] u);
    if ((u == UOP_LB) || (u == UOP_LBU) || (u == UOP_SB)) return SZ_B;
    if ((u == UOP_LH) || (u == UOP_LHU) || (u == UOP_SH)) return SZ_H;
    return SZ_W;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store-data lane replication
// and load-data lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [7:0]  uop_i,
  input  logic [1:0]  a_lo_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] ld_o
);

  logic [7:0]  lb;
  logic [15:0] lh;

  // lane selection, replication and extension
  always_comb begin
    be_o = 4'hF;
    wd_o = wd_i;
    ld_o = rd_i;
    lb   = rd_i[{a_lo_i, 3'b000} +: 8];
    lh   = rd_i[{a_lo_i[1], 4'b0000} +: 16];
    case (uop_size(uop_i))
      SZ_B: begin
        be_o = 4'b0001 << a_lo_i;
        wd_o = {4{wd_i[7:0]}};
      end
      SZ_H: begin
        be_o = 4'b0011 << a_lo_i;
        wd_o = {2{wd_i[15:0]}};
      end
      default: ;
    endcase
    case (uop_i)
      UOP_LB:  ld_o = {{24{lb[7]}}, lb};
      UOP_LBU: ld_o = {24'h0, lb};
      UOP_LH:  ld_o = {{16{lh[15]}}, lh};
      UOP_LHU: ld_o = {16'h0, lh};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit. Issues data-bus transactions with a
// req/gnt/rvalid handshake, stalls the pipeline while one is in flight and
// registers the write-back result. A flushed transaction still completes on
// the bus but its response is dropped. Build macro LSU_MISALIGN_EXC_EN makes
// misaligned accesses trap; without it the address is forced to alignment.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic [7:0]        uop_i,
  input  logic [ADDR_W-1:0] mem_a_i,
  input  logic [DATA_W-1:0] mem_wd_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_wa_i,
  input  logic [31:0]       rd_wd_i,
  input  logic [31:0]       exception_i,
  input  logic [31:0]       pc_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [3:0]        dbus_be_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wd_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rd_i,
  output logic              rd_we_o,
  output logic [4:0]        rd_wa_o,
  output logic [31:0]       rd_wd_o,
  output logic [31:0]       exception_o,
  output logic [31:0]       pc_o,
  output logic              stall_req_o
);

  state_e            state_q;
  logic              kill_q;
  // request latched at issue so REQ stays stable even after a flush
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  // one-entry result buffer for responses arriving during a MEM hold
  logic              buf_vld_q, buf_we_q;
  logic [4:0]        buf_wa_q;
  logic [31:0]       buf_wd_q, buf_pc_q;

  logic              ld, st, mem, mis_exc, issue, hold, done, res_we;
  logic [ADDR_W-1:0] a_mask, a_eff;
  logic [3:0]        al_be;
  logic [31:0]       al_wd, al_ld, res_wd, mis_bit;
  logic              unused_stall;

  assign ld     = is_load(uop_i);
  assign st     = is_store(uop_i);
  assign mem    = ld || st;
  assign a_mask = (uop_size(uop_i) == SZ_W) ? ADDR_W'(3) :
                  (uop_size(uop_i) == SZ_H) ? ADDR_W'(1) : '0;
`ifdef LSU_MISALIGN_EXC_EN
  assign a_eff   = mem_a_i;
  assign mis_exc = mem && ((mem_a_i & a_mask) != '0);
`else
  assign a_eff   = mem_a_i & ~a_mask;
  assign mis_exc = 1'b0;
`endif
  assign mis_bit = ld ? (32'd1 << LOAD_MISALIGN) : (32'd1 << STORE_MISALIGN);

  assign issue  = !rst_i && (state_q == S_IDLE) && mem && (exception_i == '0) &&
                  !mis_exc && !buf_vld_q && !flush_i;
  assign hold   = (stall_i[MEM_STALL_BIT] == STOP);
  assign done   = (state_q == S_WAIT) && dbus_rvalid_i && !kill_q && !flush_i;
  assign res_we = ld && rd_we_i;
  assign res_wd = ld ? al_ld : rd_wd_i;

  assign stall_req_o  = issue || (state_q != S_IDLE);
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  lsu_align u_align (
    .uop_i  (uop_i),
    .a_lo_i (a_eff[1:0]),
    .wd_i   (mem_wd_i),
    .rd_i   (dbus_rd_i),
    .be_o   (al_be),
    .wd_o   (al_wd),
    .ld_o   (al_ld)
  );

  // bus drive: latched request in REQ, live decode on the IDLE issue cycle
  always_comb begin
    dbus_req_o  = 1'b0;
    dbus_we_o   = 1'b0;
    dbus_be_o   = '0;
    dbus_addr_o = '0;
    dbus_wd_o   = '0;
    if (state_q == S_REQ) begin
      dbus_req_o  = 1'b1;
      dbus_we_o   = we_q;
      dbus_be_o   = be_q;
      dbus_addr_o = addr_q;
      dbus_wd_o   = wd_q;
    end else if (issue) begin
      dbus_req_o  = 1'b1;
      dbus_we_o   = st;
      dbus_be_o   = al_be;
      dbus_addr_o = {a_eff[ADDR_W-1:2], 2'b00};
      dbus_wd_o   = al_wd;
    end
  end

  // transaction FSM plus the registered write-back outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      wd_q        <= '0;
      buf_vld_q   <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_wa_q    <= '0;
      buf_wd_q    <= '0;
      buf_pc_q    <= '0;
      rd_we_o     <= 1'b0;
      rd_wa_o     <= '0;
      rd_wd_o     <= '0;
      exception_o <= '0;
      pc_o        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (issue) begin
          state_q <= dbus_gnt_i ? S_WAIT : S_REQ;
          addr_q  <= dbus_addr_o;
          be_q    <= dbus_be_o;
          we_q    <= dbus_we_o;
          wd_q    <= dbus_wd_o;
        end
        S_REQ: begin
          if (flush_i)    kill_q  <= 1'b1;
          if (dbus_gnt_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (flush_i) kill_q <= 1'b1;
          if (dbus_rvalid_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (flush_i) begin
        buf_vld_q   <= 1'b0;
        rd_we_o     <= 1'b0;
        rd_wa_o     <= '0;
        rd_wd_o     <= '0;
        exception_o <= '0;
        pc_o        <= '0;
      end else if (hold) begin
        if (done) begin
          buf_vld_q <= 1'b1;
          buf_we_q  <= res_we;
          buf_wa_q  <= rd_wa_i;
          buf_wd_q  <= res_wd;
          buf_pc_q  <= pc_i;
        end
      end else if (buf_vld_q) begin
        buf_vld_q   <= 1'b0;
        rd_we_o     <= buf_we_q;
        rd_wa_o     <= buf_wa_q;
        rd_wd_o     <= buf_wd_q;
        exception_o <= '0;
        pc_o        <= buf_pc_q;
      end else if (done) begin
        rd_we_o     <= res_we;
        rd_wa_o     <= rd_wa_i;
        rd_wd_o     <= res_wd;
        exception_o <= '0;
        pc_o        <= pc_i;
      end else if (stall_req_o) begin
        // in-flight cycles hand a bubble to write-back
        rd_we_o     <= 1'b0;
        rd_wa_o     <= '0;
        rd_wd_o     <= '0;
        exception_o <= '0;
        pc_o        <= '0;
      end else begin
        rd_we_o     <= rd_we_i && !mis_exc;
        rd_wa_o     <= rd_wa_i;
        rd_wd_o     <= rd_wd_i;
        exception_o <= mis_exc ? (exception_i | mis_bit) : exception_i;
        pc_o        <= pc_i;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// transactions checked against a byte-level behavioural model.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_i, rst_i, flush_i;
  logic [5:0]  stall_i;
  logic [7:0]  uop_i;
  logic [31:0] mem_a_i, mem_wd_i, rd_wd_i, exception_i, pc_i;
  logic        rd_we_i;
  logic [4:0]  rd_wa_i;
  logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o, dbus_wd_o, dbus_rd_i;
  logic        rd_we_o, stall_req_o;
  logic [4:0]  rd_wa_o;
  logic [31:0] rd_wd_o, exception_o, pc_o;

  int n_chk = 0;
  int n_err = 0;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .uop_i(uop_i), .mem_a_i(mem_a_i), .mem_wd_i(mem_wd_i),
    .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i), .rd_wd_i(rd_wd_i),
    .exception_i(exception_i), .pc_i(pc_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_be_o(dbus_be_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wd_o(dbus_wd_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rd_i(dbus_rd_i),
    .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o), .rd_wd_o(rd_wd_o),
    .exception_o(exception_o), .pc_o(pc_o), .stall_req_o(stall_req_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_ld(input logic [7:0] u);
    return u inside {UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU};
  endfunction
  function automatic bit m_st(input logic [7:0] u);
    return u inside {UOP_SB, UOP_SH, UOP_SW};
  endfunction
  function automatic int m_n(input logic [7:0] u);
    if (u inside {UOP_LB, UOP_LBU, UOP_SB}) return 1;
    if (u inside {UOP_LH, UOP_LHU, UOP_SH}) return 2;
    return 4;
  endfunction
  function automatic bit m_mis(input logic [7:0] u, input logic [31:0] a);
    return (m_ld(u) || m_st(u)) && ((a % m_n(u)) != 0);
  endfunction
  function automatic logic [31:0] m_ea(input logic [7:0] u, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
    return a;
`else
    return a - (a % m_n(u));
`endif
  endfunction
  function automatic logic [3:0] m_be(input logic [7:0] u, input logic [31:0] a);
    int b;
    b = ((1 << m_n(u)) - 1) << (m_ea(u, a) % 4);
    return b[3:0];
  endfunction
  function automatic logic [31:0] m_wd(input logic [7:0] u, input logic [31:0] wd);
    logic [63:0] m, r;
    int n;
    n = m_n(u);
    m = (64'd1 << (8 * n)) - 1;
    r = 0;
    for (int i = 0; i < 4 / n; i++) r = r | (({32'b0, wd} & m) << (8 * n * i));
    return r[31:0];
  endfunction
  function automatic logic [31:0] m_load(input logic [7:0] u, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [63:0] m, v;
    int n;
    n = m_n(u);
    m = (64'd1 << (8 * n)) - 1;
    v = ({32'b0, w} >> (8 * (m_ea(u, a) % 4))) & m;
    if ((u == UOP_LB || u == UOP_LH) && v[8 * n - 1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic drive(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exc, input logic we, input logic [4:0] wa,
                       input logic [31:0] rwd, input logic [31:0] pc);
    uop_i = u; mem_a_i = a; mem_wd_i = wd; exception_i = exc;
    rd_we_i = we; rd_wa_i = wa; rd_wd_i = rwd; pc_i = pc;
  endtask

  task automatic drive_nop();
    drive(UOP_NOP, 0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  // full bus transaction with grant after gd extra cycles, rvalid rdl cycles after grant
  task automatic mem_op(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdw, input int gd, input int rdl,
                        input logic we, input logic [4:0] wa, input logic [31:0] rwd,
                        input logic [31:0] pc);
    int nreq, nst, wc;
    bit granted, fin;
    drive(u, a, wd, 0, we, wa, rwd, pc);
    #1;
    nreq = 0; nst = 0; wc = 0; granted = 0; fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rd_i = $urandom;
      if (!granted) begin
        if (dbus_req_o) begin
          if (nreq == 0 || nreq == gd) begin
            chk("bus_addr", dbus_addr_o, m_ea(u, a) & ~32'd3);
            chk("bus_be", {28'b0, dbus_be_o}, {28'b0, m_be(u, a)});
            chk("bus_we", {31'b0, dbus_we_o}, {31'b0, m_st(u)});
            if (m_st(u)) chk("bus_wd", dbus_wd_o, m_wd(u, wd));
          end
          if (nreq == gd) begin dbus_gnt_i = 1'b1; granted = 1; end
          nreq++;
        end
      end else begin
        wc++;
        if (wc == rdl) begin dbus_rvalid_i = 1'b1; dbus_rd_i = rdw; fin = 1; end
      end
      if (stall_req_o) nst++;
      step();
    end
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    drive_nop();
    chk("op_done", {31'b0, fin}, 32'd1);
    chk("req_cycles", nreq, gd + 1);
    chk("stall_cycles", nst, gd + 1 + rdl);
    chk("wb_we", {31'b0, rd_we_o}, {31'b0, m_ld(u) && we});
    chk("wb_wd", rd_wd_o, m_ld(u) ? m_load(u, a, rdw) : rwd);
    chk("wb_wa", {27'b0, rd_wa_o}, {27'b0, wa});
    chk("wb_pc", pc_o, pc);
    chk("wb_exc", exception_o, 32'd0);
  endtask

  // an op that must not touch the bus; result appears one edge later
  task automatic pass_op(input logic [7:0] u, input logic [31:0] a, input logic [31:0] exc,
                         input logic we, input logic [4:0] wa, input logic [31:0] rwd,
                         input logic [31:0] pc);
    logic [31:0] e_exc;
    logic e_we;
    drive(u, a, 32'h0, exc, we, wa, rwd, pc);
    #1;
    chk("pass_noreq", {31'b0, dbus_req_o}, 32'd0);
    chk("pass_nostall", {31'b0, stall_req_o}, 32'd0);
    e_exc = exc; e_we = we;
`ifdef LSU_MISALIGN_EXC_EN
    if (m_mis(u, a)) begin
      e_we = 1'b0;
      e_exc = exc | (m_ld(u) ? 32'h10 : 32'h40);
    end
`endif
    step();
    chk("pass_we", {31'b0, rd_we_o}, {31'b0, e_we});
    chk("pass_wa", {27'b0, rd_wa_o}, {27'b0, wa});
    chk("pass_wd", rd_wd_o, rwd);
    chk("pass_exc", exception_o, e_exc);
    chk("pass_pc", pc_o, pc);
  endtask

  logic [7:0] ulist [10];

  initial begin
    ulist = '{UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU, UOP_SB, UOP_SH, UOP_SW,
              UOP_NOP, 8'h05};
    rst_i = 1'b1; flush_i = 1'b0; stall_i = 6'h0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rd_i = 0;
    drive(UOP_LW, 32'h100, 0, 0, 1'b1, 5'd3, 32'h1, 32'h40);
    step();
    // reset state: a pending load must not request while reset is held
    chk("rst_req", {31'b0, dbus_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst_we", {31'b0, rd_we_o}, 32'd0);
    chk("rst_wa", {27'b0, rd_wa_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_exc", exception_o, 32'd0);
    drive_nop();
    #1;
    rst_i = 1'b0;
    step();

    // basic loads/stores
    mem_op(UOP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b1, 5'd1, 32'h0, 32'h1000);
    mem_op(UOP_LB, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 1'b1, 5'd2, 32'h0, 32'h1004);
    mem_op(UOP_LBU, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, 1'b1, 5'd3, 32'h0, 32'h1008);
    mem_op(UOP_SH, 32'h102, 32'h1234, 32'h0, 3, 1, 1'b0, 5'd4, 32'h77, 32'h100C);

    // misaligned word load
`ifdef LSU_MISALIGN_EXC_EN
    pass_op(UOP_LW, 32'h101, 32'h0, 1'b1, 5'd5, 32'h99, 32'h1010);
    pass_op(UOP_SH, 32'h103, 32'h0, 1'b0, 5'd6, 32'h98, 32'h1014);
`else
    mem_op(UOP_LW, 32'h101, 32'h0, 32'hA5A5_5A5A, 0, 1, 1'b1, 5'd5, 32'h0, 32'h1010);
`endif

    // flush while waiting: response dropped, then a normal load completes
    drive(UOP_LW, 32'h200, 0, 0, 1'b1, 5'd8, 32'h0, 32'h300);
    #1;
    chk("fw_req", {31'b0, dbus_req_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0; flush_i = 1'b1; drive_nop();
    step();
    flush_i = 1'b0;
    chk("fw_nop_we", {31'b0, rd_we_o}, 32'd0);
    chk("fw_nop_pc", pc_o, 32'd0);
    chk("fw_stall", {31'b0, stall_req_o}, 32'd1);
    dbus_rvalid_i = 1'b1; dbus_rd_i = 32'hCAFEF00D;
    step();
    dbus_rvalid_i = 1'b0;
    chk("fw_kill_we", {31'b0, rd_we_o}, 32'd0);
    chk("fw_kill_wd", rd_wd_o, 32'd0);
    chk("fw_idle", {31'b0, stall_req_o}, 32'd0);
    mem_op(UOP_LW, 32'h204, 32'h0, 32'h01234567, 0, 1, 1'b1, 5'd9, 32'h0, 32'h304);

    // flush while requesting: request held with latched fields until grant
    drive(UOP_SW, 32'h400, 32'h55AA, 0, 1'b0, 5'd0, 32'h0, 32'h500);
    #1;
    step();
    flush_i = 1'b1; drive_nop();
    #1;
    chk("fr_req", {31'b0, dbus_req_o}, 32'd1);
    chk("fr_addr", dbus_addr_o, 32'h400);
    chk("fr_we", {31'b0, dbus_we_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    step();
    flush_i = 1'b0; dbus_gnt_i = 1'b0;
    chk("fr_noreq", {31'b0, dbus_req_o}, 32'd0);
    dbus_rvalid_i = 1'b1;
    chk("fr_stall", {31'b0, stall_req_o}, 32'd1);
    step();
    dbus_rvalid_i = 1'b0;
    chk("fr_done", {31'b0, stall_req_o}, 32'd0);
    chk("fr_we_o", {31'b0, rd_we_o}, 32'd0);

    // MEM hold while the response arrives
    pass_op(8'h05, 32'h0, 32'h0, 1'b1, 5'd7, 32'h55, 32'h200);
    drive(UOP_LW, 32'h300, 0, 0, 1'b1, 5'd9, 32'h0, 32'h204);
    stall_i = 6'h10;
    #1;
    chk("h_req", {31'b0, dbus_req_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rd_i = 32'h11223344;
    step();
    dbus_rvalid_i = 1'b0;
    chk("h_held_wd", rd_wd_o, 32'h55);
    chk("h_held_wa", {27'b0, rd_wa_o}, 32'd7);
    chk("h_noreissue", {31'b0, dbus_req_o}, 32'd0);
    chk("h_nostall", {31'b0, stall_req_o}, 32'd0);
    step();
    chk("h_held2", rd_wd_o, 32'h55);
    stall_i = 6'h0;
    step();
    drive_nop();
    chk("h_buf_wd", rd_wd_o, 32'h11223344);
    chk("h_buf_we", {31'b0, rd_we_o}, 32'd1);
    chk("h_buf_pc", pc_o, 32'h204);

    // reset in the middle of a transaction
    drive(UOP_LW, 32'h600, 0, 0, 1'b1, 5'd1, 32'h0, 32'h700);
    #1;
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0; rst_i = 1'b1;
    #1;
    chk("mr_req", {31'b0, dbus_req_o}, 32'd0);
    chk("mr_stall", {31'b0, stall_req_o}, 32'd0);
    step();
    rst_i = 1'b0;
    pass_op(UOP_NOP, 32'h0, 32'h0, 1'b1, 5'd12, 32'hABCD, 32'h800);

    // randomized mix
    for (int k = 0; k < 40; k++) begin
      logic [7:0]  u;
      logic [31:0] a, exc;
      u   = ulist[$urandom_range(0, 9)];
      a   = $urandom;
      exc = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0;
`ifdef LSU_MISALIGN_EXC_EN
      if ((m_ld(u) || m_st(u)) && exc == 0 && !m_mis(u, a))
`else
      if ((m_ld(u) || m_st(u)) && exc == 0)
`endif
        mem_op(u, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
               1'($urandom), 5'($urandom), $urandom, $urandom);
      else
        pass_op(u, a, exc, 1'($urandom), 5'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
